// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// A two-state controller (IDLE/RUN) walks an h/v counter pair on each pixel
// tick. Sync, data-enable and active-area coordinates are decoded from the
// next-state counters and registered, so every output describes the same
// h/v position that the counter outputs show in that cycle.
// Starting and stopping are frame aligned: the generator only leaves RUN on
// the pixel tick that wraps (H_TOTAL-1, V_TOTAL-1) to (0,0).
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int FCW      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_en,
  input  logic           enable,
  output logic [CW-1:0]  h_counter,
  output logic [CW-1:0]  v_counter,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           de,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start,
  output logic           running,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  h_q, h_d;
  logic [CW-1:0]  v_q, v_d;
  logic [CW-1:0]  x_q, x_d;
  logic [CW-1:0]  y_q, y_d;
  logic           de_q, de_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           ls_q, ls_d;
  logic           fs_q, fs_d;
  logic [FCW-1:0] fc_q, fc_d;

  // Zero-extended views of the next-state counters for range compares
  // against the integer timing parameters.
  logic [31:0]    h_ext;
  logic [31:0]    v_ext;
  logic           run_next;

  // Next-state logic: controller transitions, counter stepping and strobes.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    fc_d    = fc_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Start at (0,0) without advancing; the first step is the next tick.
        if (enable && pix_en) begin
          state_d = RUN;
          h_d     = '0;
          v_d     = '0;
          ls_d    = 1'b1;
          fs_d    = 1'b1;
        end
      end
      RUN: begin
        if (pix_en) begin
          if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
              // Frame wrap: the only point where the run request is honoured.
              v_d  = '0;
              fc_d = fc_q + FCW'(1);
              if (enable) begin
                ls_d = 1'b1;
                fs_d = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              v_d  = v_q + CW'(1);
              ls_d = 1'b1;
            end
          end else begin
            h_d = h_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode sync, data-enable and coordinates from the next-state position.
  always_comb begin
    h_ext    = 32'(h_d);
    v_ext    = 32'(v_d);
    run_next = (state_d == RUN);
    de_d     = run_next && (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
    x_d      = de_d ? h_d : '0;
    y_d      = de_d ? v_d : '0;
    hs_d     = (run_next && (h_ext >= HS_START) && (h_ext < HS_END))
               ? HS_POL : ~HS_POL;
    // v only changes alongside the h wrap, so vsync edges land on h = 0.
    vs_d     = (run_next && (v_ext >= VS_START) && (v_ext < VS_END))
               ? VS_POL : ~VS_POL;
  end

  // State and output registers; reset puts syncs at their inactive levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

  assign h_counter   = h_q;
  assign v_counter   = v_q;
  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign running     = (state_q == RUN);
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// Three instances share clock, reset, pix_en and enable:
//   d - default 800x525 timing (line-level checks, mid-line reset)
//   c - 320-wide, active-high hsync, CW=9 (480-pixel line)
//   s - tiny 16x8 raster so whole frames fit in a short run
`timescale 1ns/1ps

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic enable = 1'b0;

  always #5 clk = ~clk;

  // Default instance
  logic [9:0]  d_h, d_v, d_x, d_y;
  logic        d_de, d_hsync, d_vsync, d_ls, d_fs, d_running;
  logic [15:0] d_fc;

  vga_timing_gen u_d (
    .clk(clk), .reset(reset), .pix_en(pix_en), .enable(enable),
    .h_counter(d_h), .v_counter(d_v), .x(d_x), .y(d_y), .de(d_de),
    .hsync(d_hsync), .vsync(d_vsync), .line_start(d_ls),
    .frame_start(d_fs), .running(d_running), .frame_count(d_fc)
  );

  // Second configuration: H_TOTAL=480, V_TOTAL=285, hsync active-high
  logic [8:0]  c_h, c_v, c_x, c_y;
  logic        c_de, c_hsync, c_vsync, c_ls, c_fs, c_running;
  logic [15:0] c_fc;

  vga_timing_gen #(
    .H_ACTIVE(320), .V_ACTIVE(240), .HS_POL(1'b1), .CW(9)
  ) u_c (
    .clk(clk), .reset(reset), .pix_en(pix_en), .enable(enable),
    .h_counter(c_h), .v_counter(c_v), .x(c_x), .y(c_y), .de(c_de),
    .hsync(c_hsync), .vsync(c_vsync), .line_start(c_ls),
    .frame_start(c_fs), .running(c_running), .frame_count(c_fc)
  );

  // Small raster: H_TOTAL=16 (hsync 10..12), V_TOTAL=8 (vsync 5..6)
  logic [4:0]  s_h, s_v, s_x, s_y;
  logic        s_de, s_hsync, s_vsync, s_ls, s_fs, s_running;
  logic [3:0]  s_fc;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CW(5), .FCW(4)
  ) u_s (
    .clk(clk), .reset(reset), .pix_en(pix_en), .enable(enable),
    .h_counter(s_h), .v_counter(s_v), .x(s_x), .y(s_y), .de(s_de),
    .hsync(s_hsync), .vsync(s_vsync), .line_start(s_ls),
    .frame_start(s_fs), .running(s_running), .frame_count(s_fc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, fs1, fs2, k;
    bit on, de_e;

    // ---------------- Reset values ----------------
    tick(); tick();
    check("rst_h", d_h, 0);          check("rst_v", d_v, 0);
    check("rst_x", d_x, 0);          check("rst_y", d_y, 0);
    check("rst_de", d_de, 0);        check("rst_hsync", d_hsync, 1);
    check("rst_vsync", d_vsync, 1);  check("rst_ls", d_ls, 0);
    check("rst_fs", d_fs, 0);        check("rst_running", d_running, 0);
    check("rst_fc", d_fc, 0);        check("rst_c_hsync", c_hsync, 0);

    // ---------------- Idle without enable ----------------
    reset = 1'b0; pix_en = 1'b1;
    tick(); tick(); tick();
    check("idle_running", d_running, 0);
    check("idle_h", d_h, 0);
    check("idle_fs", d_fs, 0);
    check("idle_c_hsync", c_hsync, 0);

    // ---------------- Start, then one full default line ----------------
    enable = 1'b1;
    tick();
    check("start_fs", d_fs, 1);
    check("start_running", d_running, 1);
    check("start_v", d_v, 0);
    for (int i = 0; i < 800; i++) begin
      de_e = (i < 640);
      check("line_h", d_h, i);
      check("line_de", d_de, de_e);
      check("line_x", d_x, de_e ? i : 0);
      check("line_hsync", d_hsync, (i >= 656 && i < 752) ? 0 : 1);
      check("line_vsync", d_vsync, 1);
      check("line_ls", d_ls, (i == 0));
      if (i < 480)
        check("c_hsync", c_hsync, (i >= 336 && i < 432) ? 1 : 0);
      if (i == 480) begin
        check("c_wrap_h", c_h, 0);
        check("c_wrap_v", c_v, 1);
        check("c_wrap_ls", c_ls, 1);
      end
      tick();
    end
    check("wrap_h", d_h, 0);    check("wrap_v", d_v, 1);
    check("wrap_ls", d_ls, 1);  check("wrap_fs", d_fs, 0);
    check("wrap_y", d_y, 1);    check("wrap_de", d_de, 1);
    check("c_h_320", c_h, 320); check("c_de_320", c_de, 0);
    check("c_x_320", c_x, 0);

    // ---------------- Asynchronous reset mid-line ----------------
    for (int i = 0; i < 300; i++) tick();
    check("pre_rst_h", d_h, 300);
    check("pre_rst_x", d_x, 300);
    #3 reset = 1'b1;
    #1;
    check("arst_h", d_h, 0);           check("arst_v", d_v, 0);
    check("arst_x", d_x, 0);           check("arst_y", d_y, 0);
    check("arst_de", d_de, 0);         check("arst_hsync", d_hsync, 1);
    check("arst_running", d_running, 0);
    check("arst_c_hsync", c_hsync, 0);
    tick();

    // ---------------- Small raster: two full frames ----------------
    reset = 1'b0;
    tick();                           // enable and pix_en high: start
    fs1 = -1; fs2 = -1;
    for (t = 0; t <= 256; t++) begin
      int h, v;
      h = t % 16;
      v = (t / 16) % 8;
      de_e = (h < 8) && (v < 4);
      check("s_h", s_h, h);
      check("s_v", s_v, v);
      check("s_de", s_de, de_e);
      check("s_y", s_y, de_e ? v : 0);
      check("s_hsync", s_hsync, (h >= 10 && h < 13) ? 0 : 1);
      check("s_vsync", s_vsync, (v >= 5 && v < 7) ? 0 : 1);
      check("s_fs", s_fs, (t % 128 == 0));
      check("s_ls", s_ls, (h == 0));
      check("s_fc", s_fc, (t / 128) % 16);
      if (s_fs) begin
        if (fs1 < 0) fs1 = t;
        else if (fs2 < 0) fs2 = t;
      end
      tick();
    end
    check("s_frame_len", fs2 - fs1, 128);

    // ---------------- pix_en one cycle in four ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    pix_en = 1'b0;
    tick();
    check("div_idle", s_running, 0);
    fs1 = -1; fs2 = -1;
    for (int c = 0; c < 4 * 128 + 4; c++) begin
      pix_en = (c % 4 == 0);
      tick();
      k  = c / 4;
      on = (c % 4 == 0);
      check("div_h", s_h, k % 16);
      check("div_fs", s_fs, on && (k % 128 == 0));
      check("div_ls", s_ls, on && (k % 16 == 0));
      if (s_fs) begin
        if (fs1 < 0) fs1 = c;
        else if (fs2 < 0) fs2 = c;
      end
    end
    check("div_frame_len", fs2 - fs1, 512);
    pix_en = 1'b1;

    // ---------------- Drop enable mid-frame ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    tick();                           // start, t = 0
    t = 0;
    while (s_running && t < 300) begin
      if (t == 40) enable = 1'b0;
      tick();
      t++;
    end
    check("stop_at", t, 128);
    check("stop_h", s_h, 0);          check("stop_v", s_v, 0);
    check("stop_fc", s_fc, 1);        check("stop_hsync", s_hsync, 1);
    check("stop_vsync", s_vsync, 1);  check("stop_fs", s_fs, 0);
    check("stop_ls", s_ls, 0);        check("stop_de", s_de, 0);
    tick(); tick(); tick();
    check("idle2_running", s_running, 0);
    check("idle2_fc", s_fc, 1);
    enable = 1'b1;
    tick();
    check("restart_fs", s_fs, 1);
    check("restart_running", s_running, 1);

    // ---------------- Enable sampled exactly at the frame wrap ----------
    for (int i = 0; i < 127; i++) tick();
    check("end_h", s_h, 15);
    check("end_v", s_v, 7);
    enable = 1'b0;                    // low only on the wrapping tick
    tick();
    check("edge_stop_running", s_running, 0);
    check("edge_stop_fc", s_fc, 2);
    check("edge_stop_fs", s_fs, 0);
    enable = 1'b1;
    tick();
    check("edge_restart_fs", s_fs, 1);
    enable = 1'b0;                    // low all frame, high at the wrap
    for (int i = 0; i < 127; i++) tick();
    check("hold_running", s_running, 1);
    check("hold_h", s_h, 15);
    enable = 1'b1;
    tick();
    check("edge_stay_running", s_running, 1);
    check("edge_stay_fs", s_fs, 1);
    check("edge_stay_fc", s_fc, 3);
    check("edge_stay_h", s_h, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
